// File: rtl/hm_nonce_dispatch.sv
// Nonce-sweep controller: deals one nonce per cycle to idle hashing cores and stops on the first hash below target.
// All outputs registered (1-cycle decisions); cores pace the sweep by holding busy until core_done or core_quit.
module hm_nonce_dispatch #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32,
  parameter int HASH_W    = 256
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NONCE_W-1:0]            nonce_start,
  input  logic [NONCE_W-1:0]            nonce_end,
  input  logic [HASH_W-1:0]             difficulty,
  output logic [NUM_CORES-1:0]          core_begin,
  output logic [NUM_CORES-1:0]          core_quit,
  output logic [NUM_CORES*NONCE_W-1:0]  core_nonce,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES*HASH_W-1:0]   core_hash,
  output logic                          busy,
  output logic                          found,
  output logic [NONCE_W-1:0]            found_nonce,
  output logic [HASH_W-1:0]             found_hash,
  output logic                          exhausted,
  output logic [NONCE_W:0]              hashes_tried
);

  localparam int CW = NONCE_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FOUND, S_EXH} state_t;

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic [NUM_CORES-1:0]               r_core_busy;
  logic [NUM_CORES-1:0][NONCE_W-1:0]  r_core_nonce;
  logic [NUM_CORES-1:0]               r_begin;
  logic [NUM_CORES-1:0]               r_quit;
  logic [NONCE_W-1:0]                 r_next_nonce;
  logic [NONCE_W-1:0]                 r_end;
  logic [HASH_W-1:0]                  r_diff;
  logic                               r_last_issued;
  logic                               r_busy;
  logic                               r_found;
  logic [NONCE_W-1:0]                 r_found_nonce;
  logic [HASH_W-1:0]                  r_found_hash;
  logic                               r_exh;
  logic [CW-1:0]                      r_tried;

  logic [NUM_CORES-1:0]               w_acc;
  logic [NUM_CORES-1:0]               w_busy_left;
  logic [NUM_CORES-1:0]               w_disp_mask;
  logic                               w_dispatch;
  logic                               w_win;
  logic [NONCE_W-1:0]                 w_win_nonce;
  logic [HASH_W-1:0]                  w_win_hash;
  logic                               w_exh;
  logic [CW-1:0]                      w_acc_cnt;

  always_comb begin
    w_acc       = '0;
    w_win       = 1'b0;
    w_win_nonce = '0;
    w_win_hash  = '0;
    w_disp_mask = '0;
    w_acc_cnt   = '0;
    if (r_state == S_RUN) w_acc = core_done & r_core_busy;
    // Walk high-to-low so the lowest index is the last (winning) write.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_acc[i] && (core_hash[i*HASH_W +: HASH_W] < r_diff)) begin
        w_win       = 1'b1;
        w_win_nonce = r_core_nonce[i];
        w_win_hash  = core_hash[i*HASH_W +: HASH_W];
      end
      if (!r_core_busy[i]) begin
        w_disp_mask    = '0;
        w_disp_mask[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      w_acc_cnt = w_acc_cnt + CW'(w_acc[i]);
    end
    w_busy_left = r_core_busy & ~w_acc;
    w_dispatch  = (r_state == S_RUN) && !abort && !w_win && !r_last_issued && (w_disp_mask != '0);
    w_exh       = r_last_issued && (w_busy_left == '0);

    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (abort)      w_state_nxt = S_IDLE;
        else if (w_win) w_state_nxt = S_FOUND;
        else if (w_exh) w_state_nxt = S_EXH;
      end
      S_IDLE, S_FOUND, S_EXH: begin
        if (abort)      w_state_nxt = S_IDLE;
        else if (start) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_core_busy   <= '0;
      r_core_nonce  <= '0;
      r_begin       <= '0;
      r_quit        <= '0;
      r_next_nonce  <= '0;
      r_end         <= '0;
      r_diff        <= '0;
      r_last_issued <= 1'b0;
      r_busy        <= 1'b0;
      r_found       <= 1'b0;
      r_found_nonce <= '0;
      r_found_hash  <= '0;
      r_exh         <= 1'b0;
      r_tried       <= '0;
    end else begin
      r_begin <= '0;
      r_quit  <= '0;
      if (r_state != S_RUN) begin
        if (abort) begin
          r_found       <= 1'b0;
          r_exh         <= 1'b0;
          r_found_nonce <= '0;
          r_found_hash  <= '0;
          r_tried       <= '0;
          r_busy        <= 1'b0;
        end else if (start) begin
          r_next_nonce  <= nonce_start;
          r_end         <= nonce_end;
          r_diff        <= difficulty;
          // An empty range is treated as already fully issued.
          r_last_issued <= (nonce_start > nonce_end);
          r_found       <= 1'b0;
          r_exh         <= 1'b0;
          r_found_nonce <= '0;
          r_found_hash  <= '0;
          r_tried       <= '0;
          r_busy        <= 1'b1;
        end
      end else if (abort) begin
        r_quit      <= r_core_busy;
        r_core_busy <= '0;
        r_busy      <= 1'b0;
        r_found     <= 1'b0;
        r_exh       <= 1'b0;
      end else begin
        r_tried <= r_tried + w_acc_cnt;
        if (w_win) begin
          r_found       <= 1'b1;
          r_found_nonce <= w_win_nonce;
          r_found_hash  <= w_win_hash;
          r_quit        <= w_busy_left;
          r_core_busy   <= '0;
          r_busy        <= 1'b0;
        end else begin
          r_core_busy <= w_busy_left | (w_dispatch ? w_disp_mask : '0);
          if (w_dispatch) begin
            r_begin       <= w_disp_mask;
            r_next_nonce  <= r_next_nonce + 1'b1;
            r_last_issued <= (r_next_nonce == r_end);
            for (int i = 0; i < NUM_CORES; i++) begin
              if (w_disp_mask[i]) r_core_nonce[i] <= r_next_nonce;
            end
          end
          if (w_exh) begin
            r_exh  <= 1'b1;
            r_busy <= 1'b0;
          end
        end
      end
    end
  end

  assign core_begin   = r_begin;
  assign core_quit    = r_quit;
  assign core_nonce   = r_core_nonce;
  assign busy         = r_busy;
  assign found        = r_found;
  assign found_nonce  = r_found_nonce;
  assign found_hash   = r_found_hash;
  assign exhausted    = r_exh;
  assign hashes_tried = r_tried;

endmodule

// File: tb/tb_hm_nonce_dispatch.sv
// Directed bench for hm_nonce_dispatch with a fixed-latency core model and hand-driven result strobes.
module tb_hm_nonce_dispatch;
  localparam int NC = 4;
  localparam int NW = 32;
  localparam int HW = 256;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              start, abort;
  logic [NW-1:0]     nonce_start, nonce_end;
  logic [HW-1:0]     difficulty;
  logic [NC-1:0]     core_begin, core_quit, core_done;
  logic [NC*NW-1:0]  core_nonce;
  logic [NC*HW-1:0]  core_hash;
  logic              busy, found, exhausted;
  logic [NW-1:0]     found_nonce;
  logic [HW-1:0]     found_hash;
  logic [NW:0]       hashes_tried;

  logic              model_en;
  logic [NW-1:0]     win_nonce;
  logic [NC-1:0]     m_done, t_done;
  logic [NC*HW-1:0]  m_hash, t_hash;
  logic [NC-1:0]     m_act;
  int                m_cnt [NC];
  logic [NW-1:0]     m_nonce [NC];
  int                n_begin;
  logic [NW-1:0]     q_nonce [$];
  int                n_checks = 0;
  int                n_fail = 0;

  assign core_done = m_done | t_done;
  assign core_hash = model_en ? m_hash : t_hash;

  always #5 clk = ~clk;

  hm_nonce_dispatch #(.NUM_CORES(NC), .NONCE_W(NW), .HASH_W(HW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .difficulty(difficulty),
    .core_begin(core_begin), .core_quit(core_quit), .core_nonce(core_nonce),
    .core_done(core_done), .core_hash(core_hash),
    .busy(busy), .found(found), .found_nonce(found_nonce), .found_hash(found_hash),
    .exhausted(exhausted), .hashes_tried(hashes_tried)
  );

  // Core model: result strobe a fixed number of cycles after begin, hash 0 only for win_nonce.
  always @(negedge clk) begin
    if (!n_rst) begin
      m_act  = '0;
      m_done = '0;
    end else begin
      m_done = '0;
      for (int i = 0; i < NC; i++) begin
        if (core_quit[i]) m_act[i] = 1'b0;
        if (m_act[i]) begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b1;
            m_hash[i*HW +: HW] = (m_nonce[i] == win_nonce) ? {HW{1'b0}} : {HW{1'b1}};
          end
        end
        if (core_begin[i]) begin
          n_begin = n_begin + 1;
          q_nonce.push_back(core_nonce[i*NW +: NW]);
          if (model_en) begin
            m_act[i]   = 1'b1;
            m_cnt[i]   = 6;
            m_nonce[i] = core_nonce[i*NW +: NW];
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [NW-1:0] s, input logic [NW-1:0] e, input logic [HW-1:0] d);
    nonce_start = s;
    nonce_end   = e;
    difficulty  = d;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int n = 0;
    while (!(found || exhausted) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!(found || exhausted)) check("sweep_timeout", 0, 1);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; abort = 1'b0;
    nonce_start = '0; nonce_end = '0; difficulty = '0;
    t_done = '0; t_hash = '0; m_hash = '0; m_done = '0; m_act = '0;
    model_en = 1'b0; win_nonce = 32'hDEAD_BEEF; n_begin = 0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_found", found, 0);
    check("rst_exh", exhausted, 0);
    check("rst_begin", core_begin, 0);
    check("rst_tried", hashes_tried, 0);

    // Sweep with a winner on the last nonce
    model_en = 1'b1; win_nonce = 32'h0F2B_5710; n_begin = 0;
    do_start(32'h0F2B_5706, 32'h0F2B_5710, 256'h4864C << 192);
    check("win_busy", busy, 1);
    wait_end(300);
    check("win_found", found, 1);
    check("win_nonce", found_nonce, 32'h0F2B_5710);
    check("win_hash", found_hash, 0);
    check("win_tried", hashes_tried, 11);
    check("win_busy_low", busy, 0);
    check("win_exh", exhausted, 0);
    repeat (20) @(negedge clk);
    check("win_begins", n_begin, 11);

    // No winner over 0..9
    win_nonce = 32'hFFFF_0000; n_begin = 0;
    do_start(32'd0, 32'd9, 256'h1 << 200);
    check("nw_found_clr", found, 0);
    check("nw_fnonce_clr", found_nonce, 0);
    wait_end(300);
    check("nw_exh", exhausted, 1);
    check("nw_tried", hashes_tried, 10);
    check("nw_found", found, 0);
    check("nw_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("nw_begins", n_begin, 10);

    // Wrap boundary at the top of the nonce space
    n_begin = 0; q_nonce.delete();
    do_start(32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'h1 << 200);
    wait_end(300);
    repeat (5) @(negedge clk);
    check("wrap_exh", exhausted, 1);
    check("wrap_tried", hashes_tried, 2);
    check("wrap_begins", n_begin, 2);
    if (q_nonce.size() == 2) begin
      check("wrap_n0", q_nonce[0], 32'hFFFF_FFFE);
      check("wrap_n1", q_nonce[1], 32'hFFFF_FFFF);
    end else begin
      check("wrap_qsize", q_nonce.size(), 2);
    end

    // Empty range 5..4
    n_begin = 0;
    do_start(32'd5, 32'd4, 256'h1 << 200);
    check("empty_busy_k", busy, 1);
    check("empty_exh_k", exhausted, 0);
    @(negedge clk);
    check("empty_exh_k1", exhausted, 1);
    check("empty_busy_k1", busy, 0);
    check("empty_tried", hashes_tried, 0);
    check("empty_begins", n_begin, 0);

    // Simultaneous winners on cores 1 and 3
    model_en = 1'b0;
    do_start(32'd100, 32'd199, 256'h1 << 200);
    repeat (4) @(negedge clk);
    check("sim_nonces", core_nonce, {32'd103, 32'd102, 32'd101, 32'd100});
    t_hash = {NC*HW{1'b1}};
    t_hash[1*HW +: HW] = 256'h5;
    t_hash[3*HW +: HW] = 256'h0;
    t_done = 4'b1010;
    @(negedge clk);
    t_done = '0;
    check("sim_quit", core_quit, 4'b0101);
    check("sim_found", found, 1);
    check("sim_nonce", found_nonce, 32'd101);
    check("sim_hash", found_hash, 256'h5);
    check("sim_tried", hashes_tried, 2);
    check("sim_busy", busy, 0);
    check("sim_begin", core_begin, 0);
    @(negedge clk);
    check("sim_quit_pulse", core_quit, 0);

    // Abort with all four cores busy
    do_start(32'd0, 32'd99, 256'h1 << 200);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_quit", core_quit, 4'b1111);
    check("abort_busy", busy, 0);
    check("abort_found", found, 0);
    check("abort_exh", exhausted, 0);
    check("abort_tried", hashes_tried, 0);
    t_hash = '0;
    t_done = 4'b0001;
    @(negedge clk);
    t_done = '0;
    check("late_tried", hashes_tried, 0);
    check("late_found", found, 0);
    check("late_quit", core_quit, 0);

    // Reset in the middle of a sweep
    model_en = 1'b1;
    do_start(32'd0, 32'd99, 256'h1 << 200);
    repeat (10) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 n_rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_tried", hashes_tried, 0);
    check("arst_nonce", core_nonce, 0);
    check("arst_begin", core_begin, 0);
    check("arst_flags", {found, exhausted, core_quit}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_begin = 0;
    do_start(32'd0, 32'd9, 256'h1 << 200);
    wait_end(300);
    repeat (5) @(negedge clk);
    check("post_rst_exh", exhausted, 1);
    check("post_rst_tried", hashes_tried, 10);
    check("post_rst_begins", n_begin, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
